// File: rtl/tfacc_wburst_axi_pkg.sv
// rtl/tfacc_wburst_axi_pkg.sv - shared types and constants for the burst-write AXI responder
// Purpose: scalar typedefs, AXI response encoding, FSM state codes, fixed AW field values and
//          the grant-index width helper used by the top and the arbiter.
// Ports:   none (package).
package tfacc_wburst_axi_pkg;

  typedef logic [7:0]  u8_t;
  typedef logic [31:0] u32_t;
  typedef logic [63:0] u64_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [2:0] AXSIZE_8B    = 3'd3;
  localparam logic [1:0] AXBURST_INCR = 2'b01;

  // A single requester still needs a 1-bit index so vectors never collapse to zero width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tfacc_wburst_axi_rr_arbiter.sv
// rtl/tfacc_wburst_axi_rr_arbiter.sv - round-robin arbiter over N burst requesters
// Purpose: picks the first requester after the last granted one, wrapping modulo N.
// Ports:   clk, rst (sync, active-high); req[N] request vector; advance commits the current
//          grant as the new round-robin pointer; grant is the winning index, grant_valid
//          says some request is present.
module tfacc_wburst_axi_rr_arbiter
  import tfacc_wburst_axi_pkg::*;
#(
  parameter int N  = 1,
  parameter int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [IW-1:0] grant,
  output logic          grant_valid
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] scan_idx;

  // Scan ptr+1, ptr+2, ... ptr+N; the first hit wins, so ptr itself is checked last.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    scan_idx    = '0;
    for (int off = 1; off <= N; off++) begin
      scan_idx = IW'((int'(ptr_q) + off) % N);
      if (!grant_valid && req[scan_idx]) begin
        grant       = scan_idx;
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_valid) begin
      ptr_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IW'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tfacc_wburst_axi.sv
// rtl/tfacc_wburst_axi.sv - burst-write responder turning arbitrated bursts into AXI4 writes
// Purpose: arbitrates Np burst-write requesters and issues one AW/W/B transaction per burst
//          on a 64-bit AXI master, one transaction outstanding at a time.
// Ports:   clk, rst (sync, active-high);
//          requester side: wreq/wack per port, wadr/wdata/wstb/wlen per port, wbase shared;
//          AXI master: m_aw* address channel, m_w* data channel, m_b* response channel;
//          status: busy (not idle), berr (sticky error response), berr_clr (clear berr).
module tfacc_wburst_axi
  import tfacc_wburst_axi_pkg::*;
#(
  parameter int         Np     = 1,
  parameter logic [5:0] AXI_ID = 6'd0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [Np-1:0] wreq,
  output logic [Np-1:0] wack,
  input  logic [31:0]   wadr  [Np],
  input  logic [63:0]   wdata [Np],
  input  logic [7:0]    wstb  [Np],
  input  logic [7:0]    wlen  [Np],
  input  logic [31:0]   wbase,
  output logic [31:0]   m_awaddr,
  output logic [7:0]    m_awlen,
  output logic [5:0]    m_awid,
  output logic [2:0]    m_awsize,
  output logic [1:0]    m_awburst,
  output logic          m_awvalid,
  input  logic          m_awready,
  output logic [63:0]   m_wdata,
  output logic [7:0]    m_wstrb,
  output logic          m_wlast,
  output logic          m_wvalid,
  input  logic          m_wready,
  input  logic [1:0]    m_bresp,
  input  logic          m_bvalid,
  output logic          m_bready,
  output logic          busy,
  output logic          berr,
  input  logic          berr_clr
);

  localparam int GW = idx_w(Np);

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  u32_t          awaddr_q, awaddr_d;
  u8_t           awlen_q, awlen_d;
  u8_t           cnt_q, cnt_d;
  logic          berr_q, berr_d;

  logic [GW-1:0] arb_grant;
  logic          arb_valid;
  logic          last_beat;

  // The arbiter pointer only moves when IDLE actually takes a grant.
  tfacc_wburst_axi_rr_arbiter #(.N(Np), .IW(GW)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (wreq),
    .advance    (state_q == ST_IDLE),
    .grant      (arb_grant),
    .grant_valid(arb_valid)
  );

  assign last_beat = (cnt_q == awlen_q);

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    awaddr_d = awaddr_q;
    awlen_d  = awlen_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          g_d      = arb_grant;
          awaddr_d = wbase + wadr[arb_grant];  // wraps modulo 2^32
          awlen_d  = wlen[arb_grant];
          cnt_d    = '0;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_awready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (m_wready) begin
          cnt_d = cnt_q + 8'd1;
          if (last_beat) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_bvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear has priority over an error arriving in the same cycle.
  always_comb begin
    berr_d = berr_q;
    if (berr_clr) begin
      berr_d = 1'b0;
    end else if (state_q == ST_RESP && m_bvalid && axi_resp_e'(m_bresp) != OKAY) begin
      berr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      g_q      <= '0;
      awaddr_q <= '0;
      awlen_q  <= '0;
      cnt_q    <= '0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      awaddr_q <= awaddr_d;
      awlen_q  <= awlen_d;
      cnt_q    <= cnt_d;
      berr_q   <= berr_d;
    end
  end

  // Beat accept mirrors wready for the granted port only, so the initiator advances in lockstep.
  always_comb begin
    wack = '0;
    for (int i = 0; i < Np; i++) begin
      wack[i] = (state_q == ST_DATA) && m_wready && (g_q == GW'(i));
    end
  end

  assign m_awaddr  = awaddr_q;
  assign m_awlen   = awlen_q;
  assign m_awid    = AXI_ID;
  assign m_awsize  = AXSIZE_8B;
  assign m_awburst = AXBURST_INCR;
  assign m_awvalid = (state_q == ST_ADDR);
  assign m_wdata   = wdata[g_q];
  assign m_wstrb   = wstb[g_q];
  assign m_wlast   = (state_q == ST_DATA) && last_beat;
  assign m_wvalid  = (state_q == ST_DATA);
  assign m_bready  = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign berr      = berr_q;

endmodule

// File: tb/tb_tfacc_wburst_axi.sv
// tb/tb_tfacc_wburst_axi.sv - self-checking bench for tfacc_wburst_axi with a transaction-level model
module tb_tfacc_wburst_axi;

  localparam int         NP     = 4;
  localparam logic [5:0] AXI_ID = 6'd5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] wreq, wack;
  logic [31:0]   wadr  [NP];
  logic [63:0]   wdata [NP];
  logic [7:0]    wstb  [NP];
  logic [7:0]    wlen  [NP];
  logic [31:0]   wbase;
  logic [31:0]   m_awaddr;
  logic [7:0]    m_awlen;
  logic [5:0]    m_awid;
  logic [2:0]    m_awsize;
  logic [1:0]    m_awburst;
  logic          m_awvalid, m_awready;
  logic [63:0]   m_wdata;
  logic [7:0]    m_wstrb;
  logic          m_wlast, m_wvalid, m_wready;
  logic [1:0]    m_bresp;
  logic          m_bvalid, m_bready;
  logic          busy, berr, berr_clr;

  always #5 clk = ~clk;

  tfacc_wburst_axi #(.Np(NP), .AXI_ID(AXI_ID)) dut (
    .clk(clk), .rst(rst), .wreq(wreq), .wack(wack), .wadr(wadr), .wdata(wdata), .wstb(wstb),
    .wlen(wlen), .wbase(wbase), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awid(m_awid),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .busy(busy), .berr(berr), .berr_clr(berr_clr)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Requester (initiator) state per port.
  bit          act  [NP];
  int          beat [NP];
  logic [31:0] badr [NP];
  int          blen [NP];
  logic [63:0] bdat [NP][64];
  logic [7:0]  bstb [NP][64];

  // Knobs for the AXI slave and request generator.
  int   p_aw = 100, p_w = 100, p_b = 100, p_req = 0, p_clr = 0, maxlen = 7, aw_hold = 0;
  bit   auto_req = 0, w_tgl = 0, use_fr = 0, clr_now = 0;
  logic [1:0] fr = 2'b00;
  int   cyc = 0;
  bit   b_pend = 0;

  // Transaction-level expectation: phase 0 none, 1 address offered, 2 beats, 3 response.
  int          ph, mg, mk, ml, last;
  logic [31:0] ma;
  bit          berr_m;
  int          glog[$];
  int          aw_cycles, wbeats;
  logic [31:0] last_awaddr;

  function automatic int rr_pick(input logic [NP-1:0] r, input int lst);
    int p;
    for (int off = 1; off <= NP; off++) begin
      p = (lst + off) % NP;
      if (r[p[1:0]]) return p;
    end
    return 0;
  endfunction

  function automatic bit all_quiet();
    for (int i = 0; i < NP; i++) if (act[i]) return 1'b0;
    return (ph == 0) && !b_pend;
  endfunction

  task automatic drive_ports();
    for (int i = 0; i < NP; i++) begin
      wreq[i]  = act[i];
      wadr[i]  = badr[i];
      wlen[i]  = 8'(blen[i]);
      wdata[i] = bdat[i][beat[i]];
      wstb[i]  = bstb[i][beat[i]];
    end
  endtask

  task automatic drive_slave();
    int r;
    if (aw_hold > 0) begin
      m_awready = 1'b0;
      aw_hold--;
    end else begin
      m_awready = ($urandom_range(0, 99) < p_aw);
    end
    m_wready = w_tgl ? cyc[0] : ($urandom_range(0, 99) < p_w);
    m_bvalid = b_pend && ($urandom_range(0, 99) < p_b);
    r = $urandom_range(0, 9);
    m_bresp  = use_fr ? fr : (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : (r == 2) ? 2'b01 : 2'b00;
    berr_clr = clr_now || ($urandom_range(0, 99) < p_clr);
    rst      = 1'b0;
  endtask

  task automatic start_burst(input int p, input logic [31:0] a, input int len);
    badr[p] = a;
    blen[p] = len;
    beat[p] = 0;
    act[p]  = 1'b1;
    for (int b = 0; b < 64; b++) begin
      bdat[p][b] = {$urandom(), $urandom()};
      bstb[p][b] = 8'($urandom());
    end
    drive_ports();
  endtask

  task automatic model_reset();
    ph = 0; mg = 0; mk = 0; ml = 0; last = NP - 1; ma = '0;
    berr_m = 1'b0; b_pend = 1'b0;
    glog.delete();
    for (int i = 0; i < NP; i++) begin
      act[i] = 1'b0; beat[i] = 0; blen[i] = 0; badr[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    drive_ports();
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00; berr_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, advance model and initiators at the edge, drive anew.
  task automatic cycle();
    logic [NP-1:0] exp_wack, wack_s;
    logic          wlast_s, w_hs, b_hs;
    bit            dropped;
    int            len;
    @(negedge clk);
    chk_val("busy",    64'(busy),      64'(ph != 0));
    chk_val("awvalid", 64'(m_awvalid), 64'(ph == 1));
    chk_val("wvalid",  64'(m_wvalid),  64'(ph == 2));
    chk_val("bready",  64'(m_bready),  64'(ph == 3));
    chk_val("berr",    64'(berr),      64'(berr_m));
    chk_val("awfix",   64'({m_awid, m_awsize, m_awburst}), 64'({AXI_ID, 3'd3, 2'b01}));
    exp_wack = '0;
    if (ph == 1) begin
      chk_val("awaddr", 64'(m_awaddr), 64'(ma));
      chk_val("awlen",  64'(m_awlen),  64'(ml));
    end
    if (ph == 2) begin
      exp_wack[mg[1:0]] = m_wready;
      chk_val("wdata", m_wdata, bdat[mg][mk]);
      chk_val("wstrb", 64'(m_wstrb), 64'(bstb[mg][mk]));
      chk_val("wlast", 64'(m_wlast), 64'(mk == ml));
    end
    chk_val("wack", 64'(wack), 64'(exp_wack));
    if (m_awvalid) begin
      aw_cycles++;
      last_awaddr = m_awaddr;
    end
    wack_s  = wack;
    wlast_s = m_wlast;
    w_hs    = m_wvalid && m_wready;
    b_hs    = m_bvalid && m_bready;
    if (w_hs) wbeats++;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      case (ph)
        0: if (wreq != '0) begin
             mg = rr_pick(wreq, last);
             last = mg;
             ma = wbase + badr[mg];
             ml = blen[mg];
             glog.push_back(mg);
             ph = 1;
           end
        1: if (m_awready) begin ph = 2; mk = 0; end
        2: if (m_wready) begin
             if (mk == ml) ph = 3;
             else mk++;
           end
        3: if (m_bvalid) begin
             ph = 0;
             if (m_bresp != 2'b00) berr_m = 1'b1;
           end
        default: ph = 0;
      endcase
      if (berr_clr) berr_m = 1'b0;
      if (w_hs && wlast_s) b_pend = 1'b1;
      if (b_hs) b_pend = 1'b0;
      for (int i = 0; i < NP; i++) begin
        dropped = 1'b0;
        if (wack_s[i]) begin
          if (beat[i] == blen[i]) begin
            act[i] = 1'b0;
            dropped = 1'b1;
          end else begin
            beat[i]++;
          end
        end
        if (auto_req && !act[i] && !dropped && $urandom_range(0, 99) < p_req) begin
          len = ($urandom_range(0, 9) == 0) ? 63 : $urandom_range(0, maxlen);
          start_burst(i, $urandom() & 32'hFFFF_FE00, len);
        end
      end
    end
    drive_ports();
    drive_slave();
  endtask

  task automatic run_until_done(input string tag, input int maxc);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!all_quiet() && n < maxc);
    chk_val(tag, 64'(all_quiet()), 64'd1);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int gcnt[NP];
  int n;

  initial begin
    wbase = '0;
    do_reset();
    drive_slave();
    chk_val("rst_busy",    64'(busy),      64'd0);
    chk_val("rst_awvalid", 64'(m_awvalid), 64'd0);
    chk_val("rst_wvalid",  64'(m_wvalid),  64'd0);
    chk_val("rst_bready",  64'(m_bready),  64'd0);
    chk_val("rst_berr",    64'(berr),      64'd0);
    chk_val("rst_wack",    64'(wack),      64'd0);

    // T1: 8-beat burst, full-rate slave.
    wbase = 32'h1000_0000;
    wbeats = 0;
    start_burst(0, 32'h0000_0200, 7);
    drive_slave();
    run_until_done("t1_done", 60);
    chk_val("t1_awaddr", 64'(last_awaddr), 64'h1000_0200);
    chk_val("t1_beats",  64'(wbeats),      64'd8);

    // T2: all ports at once, single-beat bursts -> rotation 0,1,2,3 then 0 again.
    do_reset();
    wbase = 32'h2000_0000;
    for (int i = 0; i < NP; i++) start_burst(i, 32'(i * 32'h200), 0);
    drive_slave();
    run_until_done("t2_done_a", 80);
    start_burst(0, 32'h0000_1000, 0);
    drive_slave();
    run_until_done("t2_done_b", 40);
    chk_val("t2_count", 64'(glog.size()), 64'd5);
    for (int k = 0; k < 5 && k < glog.size(); k++)
      chk_val($sformatf("t2_grant%0d", k), 64'(glog[k]), 64'(exp_order[k]));

    // T3: wready toggling, 4 beats.
    w_tgl = 1'b1;
    wbeats = 0;
    start_burst(2, 32'h0000_0400, 3);
    drive_slave();
    run_until_done("t3_done", 60);
    chk_val("t3_beats", 64'(wbeats), 64'd4);
    w_tgl = 1'b0;

    // T4: error response is sticky across an OKAY burst, cleared by berr_clr.
    use_fr = 1'b1;
    fr = 2'b10;
    start_burst(1, 32'h0000_0600, 1);
    drive_slave();
    run_until_done("t4_done_a", 40);
    chk_val("t4_berr_set", 64'(berr), 64'd1);
    fr = 2'b00;
    start_burst(3, 32'h0000_0800, 2);
    drive_slave();
    run_until_done("t4_done_b", 40);
    chk_val("t4_berr_sticky", 64'(berr), 64'd1);
    clr_now = 1'b1;
    drive_slave();
    clr_now = 1'b0;
    cycle();
    chk_val("t4_berr_clr", 64'(berr), 64'd0);
    use_fr = 1'b0;

    // T5: reset at beat 3 of 8.
    start_burst(1, 32'h0000_0A00, 7);
    drive_slave();
    n = 0;
    while (!(ph == 2 && mk == 2) && n < 40) begin
      cycle();
      n++;
    end
    chk_val("t5_reached", 64'(ph == 2 && mk == 2), 64'd1);
    rst = 1'b1;
    cycle();
    cycle();
    chk_val("t5_busy",    64'(busy),      64'd0);
    chk_val("t5_awvalid", 64'(m_awvalid), 64'd0);
    chk_val("t5_wvalid",  64'(m_wvalid),  64'd0);
    chk_val("t5_wack",    64'(wack),      64'd0);

    // T6: address wrap and a stalled AW channel.
    wbase = 32'hFFFF_FF00;
    aw_cycles = 0;
    start_burst(3, 32'h0000_0100, 3);
    aw_hold = 6;
    drive_slave();
    run_until_done("t6_done", 60);
    chk_val("t6_awaddr",    64'(last_awaddr), 64'h0);
    chk_val("t6_aw_cycles", 64'(aw_cycles),   64'd6);

    // Random traffic with a randomly stalling slave and occasional error/clear.
    do_reset();
    wbase    = $urandom();
    auto_req = 1'b1;
    p_req = 20; p_aw = 60; p_w = 60; p_b = 50; p_clr = 3; maxlen = 7;
    drive_slave();
    repeat (3000) cycle();
    auto_req = 1'b0;
    run_until_done("rand_drain", 4000);
    for (int i = 0; i < NP; i++) gcnt[i] = 0;
    foreach (glog[k]) gcnt[glog[k]]++;
    for (int i = 0; i < NP; i++) chk_val($sformatf("rand_served%0d", i), 64'(gcnt[i] > 0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
